// File: rtl/key_pkg.sv
// Shared types and sizing helper for the key conditioner channels.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } key_state_t;

    // Counter width sized so the largest terminal count fits without wrapping.
    function automatic int cnt_w(input int db_ms, input int long_ms, input int rep_ms);
        int m;
        m = db_ms;
        if (long_ms > m) m = long_ms;
        if (rep_ms > m) m = rep_ms;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop sync, tick-based debounce, press/long/repeat FSM.
// Latency: pin->raw 2 Clk, level on DEBOUNCE_MS-th tick, pulses 1 Clk later; no backpressure.
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int REPEAT_EN   = 1
) (
    input  logic Clk,
    input  logic Reset_N,
    input  logic Tick_ms,
    input  logic Key_N,
    output logic Key_Level,
    output logic Press_Pulse,
    output logic Release_Pulse,
    output logic Long_Pulse,
    output logic Repeat_Pulse
);

    localparam int CNT_W = cnt_w(DEBOUNCE_MS, LONG_MS, REPEAT_MS);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_MS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             raw;
    logic             level_q, level_d;
    logic             falling;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    key_state_t       state_q, state_d;
    logic             press_q, press_d, release_q, release_d;
    logic             long_q, long_d, repeat_q, repeat_d;

    assign raw = ~sync2_q;

    always_comb begin
        sync1_d  = Key_N;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = db_cnt_q;
        if (raw == level_q) begin
            db_cnt_d = '0;
        end else if (Tick_ms) begin
            if (db_cnt_q == DB_LAST) begin
                level_d  = ~level_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + CNT_ONE;
            end
        end
    end

    // A release being accepted this cycle freezes hold counting so it wins over Long/Repeat.
    assign falling = level_q & ~level_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        repeat_d   = 1'b0;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                if (level_q) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!level_q) begin
                    state_d    = IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                end else if (Tick_ms && !falling) begin
                    if (hold_cnt_q == LONG_LAST) begin
                        state_d    = LONG;
                        long_d     = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end
            end
            LONG: begin
                if (!level_q) begin
                    state_d    = IDLE;
                    release_d  = 1'b1;
                    hold_cnt_d = '0;
                end else if ((REPEAT_EN != 0) && Tick_ms && !falling) begin
                    if (hold_cnt_q == REP_LAST) begin
                        repeat_d   = 1'b1;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            level_q    <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            state_q    <= IDLE;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            level_q    <= level_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            state_q    <= state_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
        end
    end

    assign Key_Level     = level_q;
    assign Press_Pulse   = press_q;
    assign Release_Pulse = release_q;
    assign Long_Pulse    = long_q;
    assign Repeat_Pulse  = repeat_q;

endmodule

// File: rtl/key_debounce_array.sv
// NUM_KEYS independent key conditioners: debounced level plus press/release/long/repeat strobes.
// Latency: level on DEBOUNCE_MS-th tick after pin settles, strobes 1 Clk later; no backpressure.
module key_debounce_array
    import key_pkg::*;
#(
    parameter int NUM_KEYS    = 4,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 200,
    parameter int REPEAT_EN   = 1
) (
    input  logic                Clk,
    input  logic                Reset_N,
    input  logic                Tick_ms,
    input  logic [NUM_KEYS-1:0] Key_N,
    output logic [NUM_KEYS-1:0] Key_Level,
    output logic [NUM_KEYS-1:0] Press_Pulse,
    output logic [NUM_KEYS-1:0] Release_Pulse,
    output logic [NUM_KEYS-1:0] Long_Pulse,
    output logic [NUM_KEYS-1:0] Repeat_Pulse
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS    (LONG_MS),
            .REPEAT_MS  (REPEAT_MS),
            .REPEAT_EN  (REPEAT_EN)
        ) u_chan (
            .Clk          (Clk),
            .Reset_N      (Reset_N),
            .Tick_ms      (Tick_ms),
            .Key_N        (Key_N[i]),
            .Key_Level    (Key_Level[i]),
            .Press_Pulse  (Press_Pulse[i]),
            .Release_Pulse(Release_Pulse[i]),
            .Long_Pulse   (Long_Pulse[i]),
            .Repeat_Pulse (Repeat_Pulse[i])
        );
    end

endmodule
